// File: rtl/ex_sta_agg_if.sv
// rtl/ex_sta_agg_if.sv - status source and EMIF read bundle for ex_sta_agg
interface ex_sta_agg_if #(
  parameter int N_SRC = 4
);
  logic [N_SRC-1:0]    src_sel;
  logic [N_SRC-1:0]    src_dval;
  logic [18*N_SRC-1:0] src_data;
  logic                rd_sel;
  logic [8:0]          rd_addr;
  logic [15:0]         rd_data;

  modport master (
    output src_sel, src_dval, src_data, rd_sel, rd_addr,
    input  rd_data
  );

  modport slave (
    input  src_sel, src_dval, src_data, rd_sel, rd_addr,
    output rd_data
  );
endinterface

// File: rtl/ex_sta_agg.sv
// rtl/ex_sta_agg.sv - expansion-case status aggregator: frame parser, per-slot liveness, EMIF read path
module ex_sta_agg #(
  parameter int N_SRC  = 4,
  parameter int N_SLOT = 16,
  parameter int TO_CYC = 150000
) (
  input  logic              clk_150m,
  input  logic              rst_150m,
  ex_sta_agg_if.slave       bus,
  output logic [N_SLOT-1:0] slot_online,
  output logic [N_SLOT-1:0] hot_plug_req
);
  localparam int CW = $clog2(TO_CYC);
  localparam logic [1:0] TAG_STA1 = 2'b00;
  localparam logic [1:0] TAG_HDR  = 2'b01;
  localparam logic [1:0] TAG_STA2 = 2'b10;

  typedef enum logic [1:0] {IDLE, W1, W2} pstate_t;

  logic [3:0]    sel_idx;
  logic          sel_any;
  logic          sel_dval;
  logic [17:0]   sel_data;
  logic [4:0]    src_cur;
  logic          src_sw;
  logic          in_dval;
  logic [17:0]   in_data;
  logic [1:0]    tag;
  logic [15:0]   payload;
  pstate_t       state, state_nx;
  logic [3:0]    slot_id, id_nx;
  logic [15:0]   sh_sta1, sh_nx;
  logic          commit, perr, id_ok, wr, err;
  logic [15:0]   sta1 [N_SLOT];
  logic [15:0]   sta2 [N_SLOT];
  logic [CW-1:0] to_cnt [N_SLOT];
  logic [15:0]   err_cnt;
  logic [15:0]   rd_word;
  logic          err_clr;

  // Descending scan so the lowest set enable bit ends up selected.
  always_comb begin
    sel_idx  = '0;
    sel_any  = 1'b0;
    sel_dval = 1'b0;
    sel_data = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (bus.src_sel[k]) begin
        sel_idx = 4'(k);
        sel_any = 1'b1;
      end
    end
    for (int k = 0; k < N_SRC; k++) begin
      if (sel_any && sel_idx == 4'(k)) begin
        sel_dval = bus.src_dval[k];
        sel_data = bus.src_data[18*k +: 18];
      end
    end
  end

  always_ff @(posedge clk_150m) begin
    if (!rst_150m) begin
      in_dval <= 1'b0;
      in_data <= '0;
      src_cur <= '0;
      src_sw  <= 1'b0;
    end else begin
      in_dval <= sel_dval;
      in_data <= sel_data;
      src_cur <= {sel_any, sel_idx};
      src_sw  <= ({sel_any, sel_idx} != src_cur);
    end
  end

  assign tag     = in_data[17:16];
  assign payload = in_data[15:0];

  always_ff @(posedge clk_150m) begin
    if (!rst_150m) begin
      state   <= IDLE;
      slot_id <= '0;
      sh_sta1 <= '0;
    end else begin
      state   <= state_nx;
      slot_id <= id_nx;
      sh_sta1 <= sh_nx;
    end
  end

  // A source switch abandons any partial frame silently; a header arriving
  // with the switch still opens a new frame.
  always_comb begin
    state_nx = state;
    id_nx    = slot_id;
    sh_nx    = sh_sta1;
    commit   = 1'b0;
    perr     = 1'b0;
    if (src_sw) begin
      state_nx = IDLE;
      if (in_dval && tag == TAG_HDR) begin
        state_nx = W1;
        id_nx    = payload[3:0];
      end
    end else if (in_dval) begin
      case (state)
        IDLE: begin
          if (tag == TAG_HDR) begin
            state_nx = W1;
            id_nx    = payload[3:0];
          end else begin
            perr = 1'b1;
          end
        end
        W1: begin
          if (tag == TAG_STA1) begin
            state_nx = W2;
            sh_nx    = payload;
          end else if (tag == TAG_HDR) begin
            perr     = 1'b1;
            state_nx = W1;
            id_nx    = payload[3:0];
          end else begin
            perr     = 1'b1;
            state_nx = IDLE;
          end
        end
        W2: begin
          if (tag == TAG_STA2) begin
            commit   = 1'b1;
            state_nx = IDLE;
          end else if (tag == TAG_HDR) begin
            perr     = 1'b1;
            state_nx = W1;
            id_nx    = payload[3:0];
          end else begin
            perr     = 1'b1;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign id_ok = ({1'b0, slot_id} < 5'(N_SLOT));
  assign wr    = commit & id_ok;
  assign err   = perr | (commit & ~id_ok);

  // A commit to a slot outranks its expiry in the same cycle.
  always_ff @(posedge clk_150m) begin
    if (!rst_150m) begin
      slot_online  <= '0;
      hot_plug_req <= '0;
      for (int i = 0; i < N_SLOT; i++) begin
        sta1[i]   <= '0;
        sta2[i]   <= '0;
        to_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SLOT; i++) begin
        hot_plug_req[i] <= 1'b0;
        if (wr && slot_id == 4'(i)) begin
          sta1[i]         <= sh_sta1;
          sta2[i]         <= payload;
          to_cnt[i]       <= '0;
          slot_online[i]  <= 1'b1;
          hot_plug_req[i] <= ~slot_online[i];
        end else if (slot_online[i]) begin
          if (to_cnt[i] == CW'(TO_CYC - 1)) begin
            slot_online[i] <= 1'b0;
            sta1[i]        <= '0;
            sta2[i]        <= '0;
            to_cnt[i]      <= '0;
          end else begin
            to_cnt[i] <= to_cnt[i] + CW'(1);
          end
        end
      end
    end
  end

  // Slot status words come back byte-swapped; status and counter words do not.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < N_SLOT; i++) begin
      if (bus.rd_addr == 9'(2*i))
        rd_word = {sta1[i][7:0], sta1[i][15:8]};
      else if (bus.rd_addr == 9'(2*i + 1))
        rd_word = {sta2[i][7:0], sta2[i][15:8]};
    end
    if (bus.rd_addr == 9'd32)
      rd_word[N_SLOT-1:0] = slot_online;
    if (bus.rd_addr == 9'd33)
      rd_word = err_cnt;
  end

  assign err_clr = bus.rd_sel && (bus.rd_addr == 9'd33);

  always_ff @(posedge clk_150m) begin
    if (!rst_150m) begin
      err_cnt     <= '0;
      bus.rd_data <= '0;
    end else begin
      if (err_clr)
        err_cnt <= {15'd0, err};
      else if (err && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
      bus.rd_data <= bus.rd_sel ? rd_word : 16'd0;
    end
  end
endmodule

// File: tb/tb_ex_sta_agg.sv
// tb/tb_ex_sta_agg.sv - scoreboard bench for ex_sta_agg
module tb_ex_sta_agg;
  localparam int N_SRC  = 4;
  localparam int N_SLOT = 8;
  localparam int TO_CYC = 8;

  logic              clk_150m = 1'b0;
  logic              rst_150m = 1'b0;
  logic [N_SLOT-1:0] slot_online;
  logic [N_SLOT-1:0] hot_plug_req;
  int                total = 0;
  int                bad   = 0;
  logic [15:0]       exp_q[$];
  string             tag_q[$];

  ex_sta_agg_if #(.N_SRC(N_SRC)) bus ();

  ex_sta_agg #(.N_SRC(N_SRC), .N_SLOT(N_SLOT), .TO_CYC(TO_CYC)) dut (
    .clk_150m    (clk_150m),
    .rst_150m    (rst_150m),
    .bus         (bus),
    .slot_online (slot_online),
    .hot_plug_req(hot_plug_req)
  );

  always #5 clk_150m = ~clk_150m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] bswap(input logic [15:0] x);
    return {x[7:0], x[15:8]};
  endfunction

  task automatic word(input int s, input logic [1:0] t, input logic [15:0] p);
    @(negedge clk_150m);
    bus.src_dval = '0;
    bus.src_dval[s] = 1'b1;
    bus.src_data[18*s +: 18] = {t, p};
  endtask

  task automatic idle();
    @(negedge clk_150m);
    bus.src_dval = '0;
  endtask

  task automatic frame(input int s, input logic [3:0] id, input logic [15:0] d1, input logic [15:0] d2);
    word(s, 2'b01, {12'd0, id});
    word(s, 2'b00, d1);
    word(s, 2'b10, d2);
    idle();
  endtask

  task automatic rd_start(input logic [8:0] addr, input logic [15:0] exp, input string tag);
    bus.rd_sel  = 1'b1;
    bus.rd_addr = addr;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic rd_finish();
    @(posedge clk_150m);
    #1;
    bus.rd_sel = 1'b0;
    chk(tag_q.pop_front(), 32'(bus.rd_data), 32'(exp_q.pop_front()));
  endtask

  task automatic rd(input logic [8:0] addr, input logic [15:0] exp, input string tag);
    @(negedge clk_150m);
    rd_start(addr, exp, tag);
    rd_finish();
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog expired");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    bus.src_sel  = 4'b0001;
    bus.src_dval = '0;
    bus.src_data = '0;
    bus.rd_sel   = 1'b0;
    bus.rd_addr  = '0;
    repeat (3) @(negedge clk_150m);
    rst_150m = 1'b1;
    repeat (2) @(negedge clk_150m);
    chk("rst_rd_data", 32'(bus.rd_data), 0);
    chk("rst_online", 32'(slot_online), 0);
    chk("rst_hotplug", 32'(hot_plug_req), 0);

    // basic frame to slot 5
    frame(0, 4'd5, 16'h1234, 16'hABCD);
    @(posedge clk_150m); #1;
    chk("basic_online", 32'(slot_online), 32'h20);
    chk("basic_hp_hi", 32'(hot_plug_req), 32'h20);
    @(posedge clk_150m); #1;
    chk("basic_hp_lo", 32'(hot_plug_req), 0);
    rd(9'd10, bswap(16'h1234), "rd_sta1_5");
    rd(9'd11, bswap(16'hABCD), "rd_sta2_5");
    rd(9'd32, 16'h0020, "rd_online");
    repeat (10) @(posedge clk_150m);
    #1;
    chk("slot5_expired", 32'(slot_online), 0);

    // timeout of slot 2
    frame(0, 4'd2, 16'h1111, 16'h2222);
    @(posedge clk_150m); #1;
    chk("to_commit", 32'(slot_online[2]), 1);
    repeat (7) @(posedge clk_150m);
    #1;
    chk("to_still_on", 32'(slot_online[2]), 1);
    @(posedge clk_150m); #1;
    chk("to_dropped", 32'(slot_online[2]), 0);
    rd(9'd4, 16'h0000, "to_sta1_clr");
    rd(9'd5, 16'h0000, "to_sta2_clr");

    // replug, then refresh landing on the expiry cycle
    frame(0, 4'd2, 16'h5566, 16'h7788);
    @(posedge clk_150m); #1;
    chk("replug_hp", 32'(hot_plug_req), 32'h04);
    @(posedge clk_150m); #1;
    chk("replug_hp_lo", 32'(hot_plug_req), 0);
    repeat (3) @(posedge clk_150m);
    frame(0, 4'd2, 16'h9ABC, 16'hDEF0);
    @(posedge clk_150m); #1;
    chk("refresh_on", 32'(slot_online[2]), 1);
    chk("refresh_no_hp", 32'(hot_plug_req), 0);
    rd(9'd4, bswap(16'h9ABC), "refresh_sta1");
    repeat (6) @(posedge clk_150m);
    #1;
    chk("refresh_still_on", 32'(slot_online[2]), 1);
    @(posedge clk_150m); #1;
    chk("refresh_expire", 32'(slot_online[2]), 0);

    // error accounting
    word(0, 2'b01, 16'd1);
    word(0, 2'b01, 16'd1);
    word(0, 2'b00, 16'h0F0F);
    word(0, 2'b11, 16'h0000);
    frame(0, 4'd15, 16'h1111, 16'h2222);
    rd(9'd33, 16'd3, "err_cnt3");
    rd(9'd33, 16'd0, "err_cleared");
    chk("bad_id_no_online", 32'(slot_online), 0);

    // same sequence, with one more error in the read cycle
    word(0, 2'b01, 16'd1);
    word(0, 2'b01, 16'd1);
    word(0, 2'b00, 16'h0F0F);
    word(0, 2'b11, 16'h0000);
    frame(0, 4'd15, 16'h1111, 16'h2222);
    word(0, 2'b11, 16'h0000);
    @(negedge clk_150m);
    bus.src_dval = '0;
    rd_start(9'd33, 16'd3, "err_inj_old");
    rd_finish();
    rd(9'd33, 16'd1, "err_inj_new");

    // source switch mid-frame
    @(negedge clk_150m);
    bus.src_sel = 4'b0010;
    idle();
    idle();
    word(1, 2'b01, 16'd3);
    word(1, 2'b00, 16'h1357);
    @(negedge clk_150m);
    bus.src_sel  = 4'b0001;
    bus.src_dval = 4'b0001;
    bus.src_data[17:0] = {2'b10, 16'h2468};
    idle();
    idle();
    chk("sw_no_commit", 32'(slot_online), 0);
    rd(9'd33, 16'd0, "sw_no_err");
    rd(9'd6, 16'd0, "sw_sta1_empty");
    frame(0, 4'd3, 16'hA1B2, 16'hC3D4);
    @(posedge clk_150m); #1;
    chk("sw_commit_on", 32'(slot_online), 32'h08);
    chk("sw_commit_hp", 32'(hot_plug_req), 32'h08);
    rd(9'd6, bswap(16'hA1B2), "sw_sta1");
    rd(9'd7, bswap(16'hC3D4), "sw_sta2");

    // reset while slot 3 is online and the parser sits in W2
    word(0, 2'b01, 16'd4);
    word(0, 2'b00, 16'h5555);
    idle();
    @(negedge clk_150m);
    rst_150m = 1'b0;
    @(posedge clk_150m); #1;
    chk("mid_rst_online", 32'(slot_online), 0);
    chk("mid_rst_hp", 32'(hot_plug_req), 0);
    chk("mid_rst_rd", 32'(bus.rd_data), 0);
    @(negedge clk_150m);
    rst_150m = 1'b1;
    idle();
    idle();
    word(0, 2'b10, 16'h9999);
    idle();
    rd(9'd6, 16'd0, "mid_rst_sta1");
    rd(9'd32, 16'd0, "mid_rst_rd32");
    rd(9'd33, 16'd1, "mid_rst_err");

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
